// File: rtl/lb_pkg.sv
// Shared definitions for the ping-pong line-buffer scheduler.
//   H_PIXELS / SRC_LINES / VIS_LINES / LAST_LINE : frame geometry
//   pixel_t      : one 8-bit pixel {chroma[7:4], luma[3:0]}
//   line_t       : one full source line, packed [H_PIXELS-1:0][7:0]
//   fill_state_t : back-bank state IDLE -> FILLING -> READY
package lb_pkg;

  localparam int unsigned H_PIXELS  = 320;
  localparam int unsigned SRC_LINES = 240;
  localparam int unsigned VIS_LINES = 480;
  localparam int unsigned LAST_LINE = 524;

  typedef logic [7:0] pixel_t;
  typedef logic [H_PIXELS-1:0][7:0] line_t;

  typedef enum logic [1:0] {
    IDLE,
    FILLING,
    READY
  } fill_state_t;

  // Even visible VGA rows are where a new source line starts.
  function automatic logic is_swap_row(input logic [9:0] row);
    return (row[0] == 1'b0) && (row < 10'(VIS_LINES));
  endfunction

endpackage

// File: rtl/line_buffer_ctrl_if.sv
// Producer <-> line-buffer controller handshake.
//   fill_req   : controller asks the producer to render fill_line into the back bank
//   fill_line  : requested source line, stable while fill_req=1
//   wr_en      : pixel write strobe
//   wr_addr    : pixel column 0..H_PIXELS-1 (larger values are dropped)
//   wr_data    : pixel value
//   fill_done  : one-cycle pulse, line complete
// Modports: master = producer (line renderer), slave = line_buffer_ctrl.
interface line_buffer_ctrl_if import lb_pkg::*; ();

  logic       fill_req;
  logic [7:0] fill_line;
  logic       wr_en;
  logic [8:0] wr_addr;
  pixel_t     wr_data;
  logic       fill_done;

  modport master (
    input  fill_req,
    input  fill_line,
    output wr_en,
    output wr_addr,
    output wr_data,
    output fill_done
  );

  modport slave (
    output fill_req,
    output fill_line,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  fill_done
  );

endinterface

// File: rtl/lb_bank.sv
// One H_PIXELS x pixel_t line bank: single write port, whole line readable at once.
//   clk, reset : clock, asynchronous active-high reset (clears every pixel)
//   wr_en      : write strobe, already qualified by the caller
//   wr_addr    : column; values outside 0..H_PIXELS-1 match no entry and are dropped
//   wr_data    : pixel to store
//   rd_data    : full packed line
module lb_bank import lb_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [8:0] wr_addr,
  input  pixel_t     wr_data,
  output line_t      rd_data
);

  line_t mem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < H_PIXELS; i++) begin
        if (wr_addr == 9'(i)) mem[i] <= wr_data;
      end
    end
  end

  assign rd_data = mem;

endmodule

// File: rtl/line_buffer_ctrl.sv
// Ping-pong line-buffer scheduler between the MARIA line renderer and VGA scan-out.
// The display reads a stable front bank while the producer fills the back bank; banks
// swap on even visible VGA rows so each source line is shown on two VGA rows.
//   clk          : pixel clock (VGA timing domain)
//   reset        : asynchronous, active-high
//   vga_line     : current VGA row 0..LAST_LINE
//   lbuffer      : front bank contents
//   fill         : producer handshake (slave side)
//   underrun     : one-cycle pulse, swap row reached with back bank not ready
//   underrun_cnt : saturating underrun count
// Build option: LB_UNDERRUN_CNT_EN enables the underrun counter; otherwise it reads 0.
module line_buffer_ctrl import lb_pkg::*; (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [9:0]               vga_line,
  output line_t                    lbuffer,
  line_buffer_ctrl_if.slave        fill,
  output logic                     underrun,
  output logic [15:0]              underrun_cnt
);

  fill_state_t state_q, state_d;
  logic        front_sel_q, front_sel_d;
  logic        req_pend_q, req_pend_d;
  logic [7:0]  req_line_q, req_line_d;
  logic [7:0]  fill_line_q, fill_line_d;
  logic        underrun_q, underrun_d;
  logic [9:0]  prev_line_q;

  logic        line_evt;
  logic        swap_pt;
  logic        vblank_start;
  logic        back_ready;
  logic [8:0]  next_src;
  logic        wr_ok;
  line_t       bank0_rd, bank1_rd;

  // Row changes are seen combinationally and acted on at the next edge.
  assign line_evt     = (vga_line != prev_line_q);
  assign swap_pt      = line_evt && is_swap_row(vga_line);
  assign vblank_start = line_evt && (vga_line == 10'(VIS_LINES));
  // A fill_done arriving with the swap row still counts as ready.
  assign back_ready   = (state_q == READY) || ((state_q == FILLING) && fill.fill_done);
  assign next_src     = 9'(vga_line[9:1]) + 9'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      front_sel_q <= 1'b0;
      req_pend_q  <= 1'b0;
      req_line_q  <= '0;
      fill_line_q <= '0;
      underrun_q  <= 1'b0;
      prev_line_q <= '0;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
      req_pend_q  <= req_pend_d;
      req_line_q  <= req_line_d;
      fill_line_q <= fill_line_d;
      underrun_q  <= underrun_d;
      prev_line_q <= vga_line;
    end
  end

  // Swap decisions override the normal FSM flow: the back bank always returns to
  // IDLE, so a new request can only start one cycle later (fill_req low >= 1 cycle).
  always_comb begin
    state_d     = state_q;
    front_sel_d = front_sel_q;
    req_pend_d  = req_pend_q;
    req_line_d  = req_line_q;
    fill_line_d = fill_line_q;
    underrun_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_pend_q) begin
          state_d     = FILLING;
          fill_line_d = req_line_q;
          req_pend_d  = 1'b0;
        end
      end
      FILLING: begin
        if (fill.fill_done) state_d = READY;
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (swap_pt) begin
      if (back_ready) front_sel_d = ~front_sel_q;
      else            underrun_d  = 1'b1;
      state_d = IDLE;
      if (next_src < 9'(SRC_LINES)) begin
        req_pend_d = 1'b1;
        req_line_d = next_src[7:0];
      end else begin
        req_pend_d = 1'b0;
      end
    end else if (vblank_start) begin
      req_pend_d = 1'b1;
      req_line_d = '0;
    end
  end

  assign fill.fill_req  = (state_q == FILLING);
  assign fill.fill_line = fill_line_q;
  assign underrun       = underrun_q;

  // Only the back bank is writable, and only while a fill is in progress.
  assign wr_ok = (state_q == FILLING) && fill.wr_en && (fill.wr_addr < 9'(H_PIXELS));

  lb_bank u_bank0 (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_ok && front_sel_q),
    .wr_addr (fill.wr_addr),
    .wr_data (fill.wr_data),
    .rd_data (bank0_rd)
  );

  lb_bank u_bank1 (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_ok && !front_sel_q),
    .wr_addr (fill.wr_addr),
    .wr_data (fill.wr_data),
    .rd_data (bank1_rd)
  );

  assign lbuffer = front_sel_q ? bank1_rd : bank0_rd;

`ifdef LB_UNDERRUN_CNT_EN
  logic [15:0] cnt_q;

  // Counted on the same edge that raises the pulse, so both are visible together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (underrun_d && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign underrun_cnt = cnt_q;
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed self-checking bench for line_buffer_ctrl.
module tb_line_buffer_ctrl;
  import lb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  vga_line;
  line_t       lbuffer;
  logic        underrun;
  logic [15:0] underrun_cnt;

  line_buffer_ctrl_if fill_if ();

  line_buffer_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .vga_line     (vga_line),
    .lbuffer      (lbuffer),
    .fill         (fill_if.slave),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  line_t mbank [2];
  int    front;

`ifdef LB_UNDERRUN_CNT_EN
  localparam int CNT_AFTER_ONE   = 1;
  localparam int CNT_AFTER_THREE = 3;
`else
  localparam int CNT_AFTER_ONE   = 0;
  localparam int CNT_AFTER_THREE = 0;
`endif

  function automatic pixel_t pix(input int s, input int c);
    return 8'(c) ^ 8'(s);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_lb(input string tag);
    line_t e;
    int    idx;
    e = mbank[front];
    checks++;
    assert (lbuffer === e) else begin
      errors++;
      idx = 0;
      for (int k = H_PIXELS - 1; k >= 0; k--) if (lbuffer[k] !== e[k]) idx = k;
      $error("FAIL %s pixel[%0d] observed=%0h expected=%0h", tag, idx, lbuffer[idx], e[idx]);
    end
  endtask

  task automatic set_line(input int l);
    vga_line = 10'(l);
    step();
  endtask

  task automatic wr(input int col, input pixel_t d, input bit accepted);
    fill_if.wr_en   = 1'b1;
    fill_if.wr_addr = 9'(col);
    fill_if.wr_data = d;
    if (accepted) mbank[1 - front][col] = d;
    step();
    fill_if.wr_en = 1'b0;
  endtask

  task automatic done_pulse();
    fill_if.fill_done = 1'b1;
    step();
    fill_if.fill_done = 1'b0;
  endtask

  task automatic fill_quick(input int s);
    wr(0, pix(s, 0), 1'b1);
    wr(1, pix(s, 1), 1'b1);
    wr(2, pix(s, 2), 1'b1);
    wr(319, pix(s, 319), 1'b1);
    done_pulse();
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    reset             = 1'b1;
    vga_line          = 10'd479;
    fill_if.wr_en     = 1'b0;
    fill_if.wr_addr   = '0;
    fill_if.wr_data   = '0;
    fill_if.fill_done = 1'b0;
    front             = 0;
    mbank[0]          = '0;
    mbank[1]          = '0;

    // Reset state
    step();
    chk("rst_fill_req", 32'(fill_if.fill_req), 32'd0);
    chk("rst_fill_line", 32'(fill_if.fill_line), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_cnt", 32'(underrun_cnt), 32'd0);
    chk_lb("rst_lbuffer");
    step();
    reset = 1'b0;
    step();
    step();

    // Test 1: vblank request for line 0, full fill, swap at row 0
    set_line(480);
    chk("t1_req_gap", 32'(fill_if.fill_req), 32'd0);
    step();
    chk("t1_req", 32'(fill_if.fill_req), 32'd1);
    chk("t1_line0", 32'(fill_if.fill_line), 32'd0);
    for (int c = 0; c < 320; c++) wr(c, pix(0, c), 1'b1);
    done_pulse();
    chk("t1_ready_req_low", 32'(fill_if.fill_req), 32'd0);
    set_line(0);
    front = 1 - front;
    chk_lb("t1_lbuffer");
    chk("t1_no_underrun", 32'(underrun), 32'd0);
    step();
    chk("t1_req1", 32'(fill_if.fill_req), 32'd1);
    chk("t1_line1", 32'(fill_if.fill_line), 32'd1);

    // Test 2: one full frame with a prompt producer
    fill_quick(1);
    for (int l = 1; l <= 524; l++) begin
      set_line(l);
      if (l < 480 && (l % 2) == 0) begin
        front = 1 - front;
        chk_lb("t2_swap_lb");
        chk("t2_underrun", 32'(underrun), 32'd0);
        step();
        s = l / 2 + 1;
        if (s < 240) begin
          chk("t2_req", 32'(fill_if.fill_req), 32'd1);
          chk("t2_line", 32'(fill_if.fill_line), 32'(s));
          fill_quick(s);
        end else begin
          chk("t2_no_req_after_239", 32'(fill_if.fill_req), 32'd0);
        end
      end else if (l < 480) begin
        chk_lb("t2_odd_same");
        if (l == 479) chk("t2_idle_479", 32'(fill_if.fill_req), 32'd0);
      end else if (l == 480) begin
        step();
        chk("t2_vblank_req", 32'(fill_if.fill_req), 32'd1);
        chk("t2_vblank_line", 32'(fill_if.fill_line), 32'd0);
        fill_quick(0);
      end
    end
    set_line(0);
    front = 1 - front;
    chk_lb("t2_wrap_lb");
    chk("t2_wrap_underrun", 32'(underrun), 32'd0);
    step();
    chk("t2_wrap_line1", 32'(fill_if.fill_line), 32'd1);

    // Test 3: producer withholds fill_done across row 4
    fill_quick(1);
    set_line(1);
    set_line(2);
    front = 1 - front;
    chk_lb("t3_swap2");
    step();
    chk("t3_line2", 32'(fill_if.fill_line), 32'd2);
    wr(0, pix(2, 0), 1'b1);
    wr(5, pix(2, 5), 1'b1);
    set_line(3);
    set_line(4);
    chk("t3_underrun", 32'(underrun), 32'd1);
    chk_lb("t3_stale_front");
    chk("t3_abort", 32'(fill_if.fill_req), 32'd0);
    chk("t3_cnt", 32'(underrun_cnt), 32'(CNT_AFTER_ONE));
    step();
    chk("t3_req_again", 32'(fill_if.fill_req), 32'd1);
    chk("t3_line3", 32'(fill_if.fill_line), 32'd3);
    chk("t3_pulse_end", 32'(underrun), 32'd0);

    // Test 4: fill_done coincident with swap row
    wr(0, pix(3, 0), 1'b1);
    wr(7, pix(3, 7), 1'b1);
    set_line(5);
    fill_if.fill_done = 1'b1;
    set_line(6);
    fill_if.fill_done = 1'b0;
    front = 1 - front;
    chk_lb("t4_swap");
    chk("t4_no_underrun", 32'(underrun), 32'd0);
    step();
    chk("t4_line4", 32'(fill_if.fill_line), 32'd4);

    // Test 5: ignored writes and ignored fill_done
    wr(0, pix(4, 0), 1'b1);
    wr(64, pix(4, 64), 1'b1);
    for (int a = 320; a < 512; a++) wr(a, 8'hEE, 1'b0);
    done_pulse();
    chk("t5_ready", 32'(fill_if.fill_req), 32'd0);
    wr(64, 8'h77, 1'b0);
    done_pulse();
    set_line(7);
    set_line(8);
    front = 1 - front;
    chk_lb("t5_swap8");
    fill_if.wr_en     = 1'b1;
    fill_if.wr_addr   = 9'd10;
    fill_if.wr_data   = 8'h99;
    fill_if.fill_done = 1'b1;
    step();
    fill_if.wr_en     = 1'b0;
    fill_if.fill_done = 1'b0;
    chk("t5_idle_done_ignored", 32'(fill_if.fill_req), 32'd1);
    chk("t5_line5", 32'(fill_if.fill_line), 32'd5);
    fill_quick(5);
    set_line(9);
    set_line(10);
    front = 1 - front;
    chk_lb("t5_swap10");
    step();
    chk("t5_line6", 32'(fill_if.fill_line), 32'd6);

    // Test 6: reset mid-fill, then forced underruns
    for (int c = 0; c <= 150; c++) wr(c, pix(6, c), 1'b1);
    #3;
    reset = 1'b1;
    #1;
    chk("t6_req_drop", 32'(fill_if.fill_req), 32'd0);
    chk("t6_line_clr", 32'(fill_if.fill_line), 32'd0);
    mbank[0] = '0;
    mbank[1] = '0;
    front    = 0;
    chk_lb("t6_lb_clr");
    vga_line = 10'd0;
    step();
    step();
    reset = 1'b0;
    step();
    chk("t6_cnt_clr", 32'(underrun_cnt), 32'd0);
    set_line(1);
    set_line(2);
    chk("t6_ur1", 32'(underrun), 32'd1);
    step();
    set_line(3);
    set_line(4);
    chk("t6_ur2", 32'(underrun), 32'd1);
    set_line(5);
    set_line(6);
    chk("t6_ur3", 32'(underrun), 32'd1);
    chk("t6_cnt", 32'(underrun_cnt), 32'(CNT_AFTER_THREE));
    chk_lb("t6_lb_still_clr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
